priority_encoder_rr: RTL and testbench
======================================

// Module: priority_encoder_rr
// PURPOSE
//   Parametrised, registered priority encoder with a valid/ready stream interface.
//   Encodes a WIDTH-bit request vector to a binary index, a one-hot grant and an "any" flag.
//   Runtime-selectable fixed-priority (MSB wins) or round-robin priority.
//   Sits between request collectors and downstream shifters/arbitration logic, one result per accepted beat.
// PARAMETERS
//   WIDTH    8                  number of request bits (>=2)
//   IDX_W    $clog2(WIDTH)      width of encoded index (derived; do not override)
// PORTS
//   clk        in   1       single clock; all state on rising edge
//   rst        in   1       asynchronous, active-high reset
//   in_req     in   WIDTH   request vector; bit WIDTH-1 highest in fixed mode
//   in_rr_en   in   1       1 = round-robin, 0 = fixed priority; sampled with the beat
//   in_valid   in   1       input beat present
//   in_ready   out  1       block can accept a beat this cycle
//   out_idx    out  IDX_W   encoded index of granted bit
//   out_onehot out  WIDTH   one-hot grant (zero when out_any=0)
//   out_any    out  1       1 if any in_req bit was set
//   out_valid  out  1       output register holds a result
//   out_ready  in   1       downstream accepts the result
// BEHAVIOUR
//   - Reset (async, rst=1): out_valid=0, out_idx=0, out_onehot=0, out_any=0, rr_ptr=0. Takes effect
//     immediately, including mid-transfer; the pending beat is discarded.
//   - in_ready = !out_valid | out_ready (combinational; single output register, no skid buffer).
//   - Accept when in_valid & in_ready. Result registered; out_valid rises the cycle after acceptance
//     (latency 1). Full throughput: one beat per cycle when out_ready held 1.
//   - While out_valid & !out_ready: all outputs held stable, in_ready=0, no input accepted.
//   - out_valid falls after out_valid & out_ready unless a new beat is accepted that same cycle
//     (simultaneous pop/push -> out_valid stays 1, outputs replaced).
//   - Fixed mode (in_rr_en=0): grant highest set bit index.
//   - Round-robin mode (in_rr_en=1): search starts at (rr_ptr-1) mod WIDTH, descending, wrapping
//     from 0 to WIDTH-1; bit rr_ptr is searched last. rr_ptr=0 at reset -> search order WIDTH-1..0,
//     identical to fixed mode.
//   - rr_ptr (internal, IDX_W bits) <= granted index on every accepted beat with out_any=1 and
//     in_rr_en=1. Unchanged on fixed-mode beats and on zero-request beats.
//   - in_req = 0: out_any=0, out_idx=0, out_onehot=0; beat still produced (out_valid=1).
//   - out_onehot always equals (1 << out_idx) when out_any=1; exactly one bit set.
//   - WIDTH not a power of two: index arithmetic wraps mod WIDTH, never produces idx >= WIDTH.
//   - No state machine beyond output-valid flag and rr_ptr; no combinational path in_req -> outputs.
// TESTING (WIDTH=8)
//   1. Fixed: in_req=8'b11100000, rr_en=0, out_ready=1 -> next cycle out_idx=7, onehot=8'b10000000,
//      any=1; in_req=8'b00000000 -> out_any=0, out_idx=0, onehot=0, out_valid=1.
//   2. RR sweep: rr_en=1, in_req=8'hFF for 3 beats from reset -> out_idx 7,6,5; then in_req=8'b10000001
//      -> idx 0 (search 4..0); then same req -> idx 7 (wrap).
//   3. RR wrap/last: rr_ptr=0, in_req=8'b00000001 -> idx 0; repeat -> idx 0 (sole requester regranted).
//   4. Backpressure: out_valid=1, out_ready=0 for 5 cycles with changing in_req -> in_ready=0,
//      outputs bit-stable; out_ready=1 -> original result consumed, then next beat accepted.
//   5. Streaming: in_valid=1, out_ready=1 for 8 beats of in_req=1<<k -> out_idx=k each cycle,
//      no bubbles; mixed rr_en per beat does not update rr_ptr on rr_en=0 beats.
//   6. Reset mid-operation: assert rst asynchronously while out_valid=1 -> out_valid=0 and outputs 0
//      before next clk edge; after release, in_req=8'hFF rr_en=1 -> idx 7 (rr_ptr cleared).

Source files
------------

// File: rtl/priority_encoder_rr.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder_rr
//  Description : Registered priority encoder with a valid/ready stream interface.
//                Supports fixed (MSB-first) and round-robin priority per beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_rr #(
  parameter int WIDTH = 8,
  // Derived from WIDTH; leave at its default.
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_req,
  input  logic             in_rr_en,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_any,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [WIDTH-1:0] out_onehot_q, out_onehot_d;
  logic             out_any_q, out_any_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             w_accept;
  logic             w_any;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_cand;
  logic [WIDTH-1:0] w_onehot;
  int               w_base;
  int               w_pos;

  assign in_ready = !out_valid_q || out_ready;
  assign w_accept = in_valid && in_ready;

  // Search descends from base-1 with wrap; base=0 reproduces fixed MSB-first order.
  always_comb begin
    w_any    = 1'b0;
    w_idx    = '0;
    w_cand   = '0;
    w_onehot = '0;
    w_pos    = 0;
    w_base   = in_rr_en ? int'(rr_ptr_q) : 0;
    for (int k = 1; k <= WIDTH; k++) begin
      w_pos = w_base - k;
      if (w_pos < 0) w_pos = w_pos + WIDTH;
      w_cand = IDX_W'(w_pos);
      if (!w_any && in_req[w_cand]) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
    if (w_any) w_onehot[w_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    out_any_d    = out_any_q;
    rr_ptr_d     = rr_ptr_q;
    if (w_accept) begin
      out_valid_d  = 1'b1;
      out_idx_d    = w_idx;
      out_onehot_d = w_onehot;
      out_any_d    = w_any;
      if (in_rr_en && w_any) rr_ptr_d = w_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      out_any_q    <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      out_any_q    <= out_any_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign out_any    = out_any_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_priority_encoder_rr
//  Description : Scoreboard bench for priority_encoder_rr (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_req;
  logic       in_rr_en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic       out_any;
  logic       out_valid;
  logic       out_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Expected result: {any, idx, onehot}
  logic [11:0] exp_q[$];

  priority_encoder_rr #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_req    (in_req),
    .in_rr_en  (in_rr_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_onehot(out_onehot),
    .out_any   (out_any),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: a result is consumed at the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [11:0] e;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(out_idx), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("out_any", 32'(out_any), 32'(e[11]));
        chk("out_idx", 32'(out_idx), 32'(e[10:8]));
        chk("out_onehot", 32'(out_onehot), 32'(e[7:0]));
      end
    end
  end

  task automatic push_exp(input logic [2:0] e_idx, input logic e_any);
    logic [7:0] oh;
    oh = e_any ? (8'd1 << e_idx) : 8'd0;
    exp_q.push_back({e_any, e_idx, oh});
  endtask

  // Present one beat, wait for acceptance (bounded), then check latency-1 valid.
  task automatic send(input logic [7:0] req, input logic rr, input logic [2:0] e_idx, input logic e_any);
    int budget;
    in_req   = req;
    in_rr_en = rr;
    in_valid = 1'b1;
    push_exp(e_idx, e_any);
    budget = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("valid_latency", 32'(out_valid), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rst = 1'b1; in_req = '0; in_rr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_onehot", 32'(out_onehot), 32'd0);
    chk("rst_any", 32'(out_any), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Fixed priority, then empty request
    send(8'b1110_0000, 1'b0, 3'd7, 1'b1);
    send(8'b0000_0000, 1'b0, 3'd0, 1'b0);

    // Round-robin sweep and wrap
    send(8'hFF, 1'b1, 3'd7, 1'b1);
    send(8'hFF, 1'b1, 3'd6, 1'b1);
    send(8'hFF, 1'b1, 3'd5, 1'b1);
    send(8'b1000_0001, 1'b1, 3'd0, 1'b1);
    send(8'b1000_0001, 1'b1, 3'd7, 1'b1);

    // Sole low requester regranted repeatedly
    send(8'b0000_0001, 1'b1, 3'd0, 1'b1);
    send(8'b0000_0001, 1'b1, 3'd0, 1'b1);
    send(8'b0000_0001, 1'b1, 3'd0, 1'b1);
    idle(3);

    // Backpressure: result A held while new requests wait
    out_ready = 1'b0;
    send(8'b0010_0100, 1'b0, 3'd5, 1'b1);
    in_valid = 1'b1;
    in_rr_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_req = 8'(8'h11 << c);
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_idx", 32'(out_idx), 32'd5);
      chk("stall_onehot", 32'(out_onehot), 32'h20);
      chk("stall_any", 32'(out_any), 32'd1);
      @(posedge clk); #1;
    end
    in_req = 8'h0C; in_rr_en = 1'b1;
    push_exp(3'd3, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("swap_valid", 32'(out_valid), 32'd1);
    idle(3);

    // Streaming one-hot requests; rr_en only on beats 2 and 5
    start = cyc;
    for (int k = 0; k < 8; k++)
      send(8'(8'd1 << k), (k == 2 || k == 5), 3'(k), 1'b1);
    chk("stream_cycles", 32'(cyc - start), 32'd8);
    send(8'hFF, 1'b1, 3'd4, 1'b1);
    idle(3);

    // Asynchronous reset with a result pending
    out_ready = 1'b0;
    send(8'hFF, 1'b1, 3'd3, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_idx", 32'(out_idx), 32'd0);
    chk("arst_onehot", 32'(out_onehot), 32'd0);
    chk("arst_any", 32'(out_any), 32'd0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(8'hFF, 1'b1, 3'd7, 1'b1);
    idle(4);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
